ck_mux_ctrl: RTL and testbench
==============================

# ck_mux_ctrl

Sequencer for the board-level glitch-free clock mux (BUFGMUX) that selects between `clk_100m` and `clk_125m` to drive the muxed clock tree. It accepts switch requests over a valid/ready handshake and holds the muxed-tree logic in reset while the clocks change. It drives the mux select, lets the tree settle, then releases the logic. It also monitors heartbeats from both source clocks and refuses or reverts any switch to a dead clock. It runs on the free-running `clk_100m` and sits beside the mux in `top`.

## Interface
Parameters:
- `QUIESCE_CYC`, default 16: number of cycles `tree_rst_n` is held low before `ck_sel` changes.
- `SETTLE_CYC`, default 64: number of cycles after a `ck_sel` change before the target clock is checked; also the post-reset hold.
- `HB_TIMEOUT`, default 256: number of `clk_100m` cycles without a heartbeat edge before a clock is declared dead.

Ports:
- `clk_100m` in 1: control clock, free-running.
- `reset_n` in 1: synchronous, active-low reset.
- `req_valid` in 1: switch request.
- `req_sel` in 1: target clock; 0 = 100 MHz, 1 = 125 MHz.
- `req_ready` out 1: high only in IDLE.
- `hb_100m_tog` in 1: heartbeat from the 100 MHz domain; toggles every 8 source cycles; asynchronous.
- `hb_125m_tog` in 1: heartbeat from the 125 MHz domain; same rules as `hb_100m_tog`.
- `ck_sel` out 1: drives BUFGMUX `S`.
- `tree_rst_n` out 1: active-low reset for the muxed-tree logic.
- `busy` out 1: high in any state other than IDLE.
- `done_pulse` out 1: one cycle; the request completed as asked.
- `err_pulse` out 1: one cycle; the request was refused or reverted.
- `ck_alive` out 2: bit0 = 100 MHz alive, bit1 = 125 MHz alive.

## Operation
- All outputs are registered.
- Reset values: `ck_sel`=0, `tree_rst_n`=0, `req_ready`=0, `busy`=1, `done_pulse`=0, `err_pulse`=0, `ck_alive`=2'b00. State = INIT.
- Heartbeat monitor, one per clock:
  - 2-FF synchroniser, then edge detect.
  - Watchdog counter clears on each edge and otherwise increments, saturating at `HB_TIMEOUT`. It resets to `HB_TIMEOUT`.
  - `ck_alive[i]` = (counter < `HB_TIMEOUT`).
- States:
  - INIT: count `SETTLE_CYC`, then go to IDLE with `tree_rst_n` set to 1.
  - IDLE: `req_ready`=1. A request is accepted when `req_valid & req_ready`; `req_sel` is latched as `tgt` and `ck_sel` is latched as `prev`.
    - `tgt == ck_sel`: no switch; pulse `done_pulse`; stay in IDLE.
    - `!ck_alive[tgt]`: pulse `err_pulse`; stay in IDLE; `tree_rst_n` untouched.
    - Otherwise: set `tree_rst_n` to 0 and go to QUIESCE.
  - QUIESCE: count `QUIESCE_CYC`. On exit, set `ck_sel` to `tgt` and go to SETTLE.
  - SETTLE: count `SETTLE_CYC`. On exit:
    - If `ck_alive[tgt]`: set `tree_rst_n` to 1, pulse `done_pulse`, go to IDLE.
    - Otherwise: set `ck_sel` to `prev` and go to REVERT.
  - REVERT: count `SETTLE_CYC`. On exit, set `tree_rst_n` to 1, pulse `err_pulse`, go to IDLE.
- A single down-counter is shared by all states. Its width is clog2 of max(`QUIESCE_CYC`, `SETTLE_CYC`)+1.
- `req_valid` is ignored while `busy`; the requester holds the request until `req_ready`.
- `reset_n` low in any state forces the reset values on the next edge. `ck_sel` returns to 0 and the sequence restarts from INIT.
- `done_pulse` and `err_pulse` are never high in the same cycle.

## Timing
- Accept at cycle T, full switch (Q=`QUIESCE_CYC`, S=`SETTLE_CYC`):
  - `tree_rst_n` = 0 from T+1.
  - `ck_sel` = `tgt` from T+Q+1.
  - `tree_rst_n` = 1, `done_pulse`, and `req_ready` all at T+Q+S+1.
  - With defaults: `ck_sel` changes at T+17; done at T+81.
- No-op or refused request: the pulse is at T+1; `req_ready` stays 1, so back-to-back requests are legal.
- Revert path: `ck_sel` = `prev` at T+Q+S+1; `err_pulse` and release at T+Q+2S+1.
- After `reset_n` deasserts at cycle R: `tree_rst_n`=1 and `req_ready`=1 at R+S+1.
- Alive latency:
  - Death: `ck_alive` falls `HB_TIMEOUT` cycles after the last heartbeat edge.
  - Recovery: `ck_alive` rises 3–4 cycles after an edge, due to synchroniser plus edge-detect delay.

## Structure
- `ck_mux_pkg`:
  - State enum `INIT`, `IDLE`, `QUIESCE`, `SETTLE`, `REVERT`.
  - `CK_SEL_100M`=1'b0, `CK_SEL_125M`=1'b1.
- Sub-module `ck_hb_mon` (synchroniser, edge detect, saturating watchdog, `alive` output), parameterised by `HB_TIMEOUT` and instantiated twice.
- The FSM and shared counter live in `ck_mux_ctrl`.

## Test plan
- Reset, then toggle both heartbeats every 8 cycles → after release, `tree_rst_n`=1 exactly at R+65 and `ck_alive`=2'b11.
- Request `req_sel`=1 accepted at T → `tree_rst_n`=0 at T+1, `ck_sel`=1 at T+17, `done_pulse` at T+81 only.
- Request `req_sel`=0 while `ck_sel`=0 → `done_pulse` at T+1, `tree_rst_n` stays 1, `ck_sel` unchanged.
- Stop `hb_125m_tog`, wait 300 cycles, request 1 → `ck_alive`=2'b01, `err_pulse` at T+1, no change to `ck_sel`.
- Stop `hb_125m_tog` at T+20 during SETTLE → `ck_sel`=0 at T+81, `err_pulse` at T+145, `tree_rst_n`=1 at T+145.
- Assert `reset_n`=0 at T+30 mid-switch → next cycle `ck_sel`=0, `tree_rst_n`=0, `busy`=1; `req_valid` held high is not accepted until IDLE.

Source files
------------

// File: rtl/ck_mux_pkg.sv
// Shared types and constants for the clock-mux sequencer and its heartbeat monitors.
package ck_mux_pkg;

    // Sequencer states: power-up hold, waiting for requests, tree held before the
    // select flips, waiting for the new clock to settle, and falling back to the
    // previous clock.
    typedef enum logic [2:0] {
        INIT,
        IDLE,
        QUIESCE,
        SETTLE,
        REVERT
    } ck_state_e;

    // BUFGMUX select encodings.
    localparam logic CK_SEL_100M = 1'b0;
    localparam logic CK_SEL_125M = 1'b1;

    // Larger of two integers; sizes the shared down-counter.
    function automatic int maxOf(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ck_mux_ctrl_hb_mon.sv
// Heartbeat monitor for one source clock: resynchronises the asynchronous toggle,
// detects its edges and declares the clock dead after HB_TIMEOUT quiet cycles.
module ck_hb_mon #(
    parameter int HB_TIMEOUT = 256
) (
    input  logic clk_i,
    input  logic reset_n_i,
    input  logic hb_tog_i,
    output logic alive_o
);

    localparam int WW = $clog2(HB_TIMEOUT + 1);
    localparam logic [WW-1:0] WD_MAX = WW'(HB_TIMEOUT);

    logic          sync1_q;
    logic          sync2_q;
    logic          sync3_q;
    logic          hbEdge;
    logic [WW-1:0] wd_q;
    logic [WW-1:0] wd_d;
    logic          alive_q;

    assign hbEdge  = sync2_q ^ sync3_q;
    assign alive_o = alive_q;

    // Watchdog next value: clear on a heartbeat edge, otherwise count up and stick at the limit.
    always_comb begin
        wd_d = wd_q;
        if (hbEdge) begin
            wd_d = '0;
        end else if (wd_q != WD_MAX) begin
            wd_d = wd_q + WW'(1);
        end
    end

    // Synchroniser chain, edge-history flop, watchdog and the registered alive flag.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            sync3_q <= 1'b0;
            wd_q    <= WD_MAX;
            alive_q <= 1'b0;
        end else begin
            sync1_q <= hb_tog_i;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
            wd_q    <= wd_d;
            alive_q <= (wd_d < WD_MAX);
        end
    end

endmodule

// File: rtl/ck_mux_ctrl.sv
// Sequencer for the glitch-free clock mux: takes switch requests, holds the muxed
// tree in reset around the select change, and falls back if the new clock is dead.
module ck_mux_ctrl
    import ck_mux_pkg::*;
#(
    parameter int QUIESCE_CYC = 16,
    parameter int SETTLE_CYC  = 64,
    parameter int HB_TIMEOUT  = 256
) (
    input  logic       clk_100m,
    input  logic       reset_n,
    input  logic       req_valid,
    input  logic       req_sel,
    output logic       req_ready,
    input  logic       hb_100m_tog,
    input  logic       hb_125m_tog,
    output logic       ck_sel,
    output logic       tree_rst_n,
    output logic       busy,
    output logic       done_pulse,
    output logic       err_pulse,
    output logic [1:0] ck_alive
);

    localparam int CNT_MAX = maxOf(QUIESCE_CYC, SETTLE_CYC);
    localparam int CW      = $clog2(CNT_MAX + 1);

    // The post-reset hold loads the full settle count so the tree is released one
    // cycle later than a plain SETTLE_CYC-1 countdown would give.
    localparam logic [CW-1:0] INIT_LOAD    = CW'(SETTLE_CYC);
    localparam logic [CW-1:0] QUIESCE_LOAD = CW'(QUIESCE_CYC - 1);
    localparam logic [CW-1:0] SETTLE_LOAD  = CW'(SETTLE_CYC - 1);

    ck_state_e     state_q;
    logic [CW-1:0] cnt_q;
    logic          tgt_q;
    logic          prev_q;
    logic          ckSel_q;
    logic          treeRstN_q;
    logic          reqReady_q;
    logic          busy_q;
    logic          done_q;
    logic          err_q;
    logic [1:0]    aliveVec;

    ck_hb_mon #(
        .HB_TIMEOUT (HB_TIMEOUT)
    ) u_hb_100m (
        .clk_i     (clk_100m),
        .reset_n_i (reset_n),
        .hb_tog_i  (hb_100m_tog),
        .alive_o   (aliveVec[0])
    );

    ck_hb_mon #(
        .HB_TIMEOUT (HB_TIMEOUT)
    ) u_hb_125m (
        .clk_i     (clk_100m),
        .reset_n_i (reset_n),
        .hb_tog_i  (hb_125m_tog),
        .alive_o   (aliveVec[1])
    );

    assign req_ready  = reqReady_q;
    assign ck_sel     = ckSel_q;
    assign tree_rst_n = treeRstN_q;
    assign busy       = busy_q;
    assign done_pulse = done_q;
    assign err_pulse  = err_q;
    assign ck_alive   = aliveVec;

    // Switch sequencer with the shared down-counter and all handshake/mux outputs registered.
    always_ff @(posedge clk_100m) begin
        if (!reset_n) begin
            state_q    <= INIT;
            cnt_q      <= INIT_LOAD;
            tgt_q      <= CK_SEL_100M;
            prev_q     <= CK_SEL_100M;
            ckSel_q    <= CK_SEL_100M;
            treeRstN_q <= 1'b0;
            reqReady_q <= 1'b0;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                INIT: begin
                    if (cnt_q == '0) begin
                        state_q    <= IDLE;
                        treeRstN_q <= 1'b1;
                        reqReady_q <= 1'b1;
                        busy_q     <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                IDLE: begin
                    if (req_valid && reqReady_q) begin
                        tgt_q  <= req_sel;
                        prev_q <= ckSel_q;
                        if (req_sel == ckSel_q) begin
                            done_q <= 1'b1;
                        end else if (!aliveVec[req_sel]) begin
                            err_q <= 1'b1;
                        end else begin
                            state_q    <= QUIESCE;
                            cnt_q      <= QUIESCE_LOAD;
                            treeRstN_q <= 1'b0;
                            reqReady_q <= 1'b0;
                            busy_q     <= 1'b1;
                        end
                    end
                end
                QUIESCE: begin
                    if (cnt_q == '0) begin
                        state_q <= SETTLE;
                        cnt_q   <= SETTLE_LOAD;
                        ckSel_q <= tgt_q;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                SETTLE: begin
                    if (cnt_q == '0) begin
                        if (aliveVec[tgt_q]) begin
                            state_q    <= IDLE;
                            treeRstN_q <= 1'b1;
                            reqReady_q <= 1'b1;
                            busy_q     <= 1'b0;
                            done_q     <= 1'b1;
                        end else begin
                            state_q <= REVERT;
                            cnt_q   <= SETTLE_LOAD;
                            ckSel_q <= prev_q;
                        end
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                REVERT: begin
                    if (cnt_q == '0) begin
                        state_q    <= IDLE;
                        treeRstN_q <= 1'b1;
                        reqReady_q <= 1'b1;
                        busy_q     <= 1'b0;
                        err_q      <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                default: begin
                    state_q    <= INIT;
                    cnt_q      <= INIT_LOAD;
                    ckSel_q    <= CK_SEL_100M;
                    treeRstN_q <= 1'b0;
                    reqReady_q <= 1'b0;
                    busy_q     <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ck_mux_ctrl.sv
// Self-checking bench for ck_mux_ctrl: randomised and directed switch requests,
// heartbeat start/stop, mid-switch reset; expectations come from a timeline model.
module tb_ck_mux_ctrl;
    import ck_mux_pkg::*;

    localparam int Q = 16;
    localparam int S = 64;
    localparam int T = 32;

    logic       clk_100m    = 1'b0;
    logic       reset_n     = 1'b0;
    logic       req_valid   = 1'b0;
    logic       req_sel     = 1'b0;
    logic       hb_100m_tog = 1'b0;
    logic       hb_125m_tog = 1'b0;
    logic       req_ready;
    logic       ck_sel;
    logic       tree_rst_n;
    logic       busy;
    logic       done_pulse;
    logic       err_pulse;
    logic [1:0] ck_alive;

    ck_mux_ctrl #(
        .QUIESCE_CYC (Q),
        .SETTLE_CYC  (S),
        .HB_TIMEOUT  (T)
    ) dut (
        .clk_100m    (clk_100m),
        .reset_n     (reset_n),
        .req_valid   (req_valid),
        .req_sel     (req_sel),
        .req_ready   (req_ready),
        .hb_100m_tog (hb_100m_tog),
        .hb_125m_tog (hb_125m_tog),
        .ck_sel      (ck_sel),
        .tree_rst_n  (tree_rst_n),
        .busy        (busy),
        .done_pulse  (done_pulse),
        .err_pulse   (err_pulse),
        .ck_alive    (ck_alive)
    );

    always #5 clk_100m = ~clk_100m;

    int errCount   = 0;
    int checkCount = 0;

    // Reference model: absolute edge numbers of reset, accepted switch and heartbeat toggles.
    int edgeCnt     = 0;
    int lastLowEdge = 0;
    bit mSel        = 1'b0;
    int opA         = -1;
    bit opTgt       = 1'b0;
    bit opPrev      = 1'b0;
    bit opRev       = 1'b0;
    bit mBusy       = 1'b1;
    bit acceptFlag  = 1'b0;
    int lastAccept  = 0;
    bit hbEn[2]     = '{1'b1, 1'b1};
    int lastTog[2]  = '{-1000, -1000};
    int prevTog[2]  = '{-1000, -1000};

    typedef struct {
        bit isErr;
        int due;
    } expPulse_t;

    expPulse_t sbQ[$];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errCount++;
            $display("[TB] FAIL %s at edge %0d: got %0d, expected %0d", name, edgeCnt, actual, expected);
        end
    endtask

    // Alive status the DUT should present when sampled at edge s: 1 alive, 0 dead, 2 too close to call.
    function automatic int aliveModel(input int i, input int s);
        int L;
        if (s <= lastLowEdge + 1) return 0;
        L = (lastTog[i] + 6 <= s) ? lastTog[i] : prevTog[i];
        if (L > lastLowEdge && L + 6 <= s && s < L + T - 4) return 1;
        if (lastTog[i] < s - T - 12 && s > lastLowEdge + T + 12) return 0;
        return 2;
    endfunction

    // Heartbeat sources: each enabled one toggles every 8 cycles.
    always @(negedge clk_100m) begin
        if (edgeCnt % 8 == 0) begin
            if (hbEn[0]) begin
                hb_100m_tog = ~hb_100m_tog;
                prevTog[0]  = lastTog[0];
                lastTog[0]  = edgeCnt;
            end
            if (hbEn[1]) begin
                hb_125m_tog = ~hb_125m_tog;
                prevTog[1]  = lastTog[1];
                lastTog[1]  = edgeCnt;
            end
        end
    end

    // Model update at each rising edge: reset, accepts, switch outcomes and scoreboard pushes.
    always @(posedge clk_100m) begin
        edgeCnt++;
        acceptFlag = 1'b0;
        if (!reset_n) begin
            lastLowEdge = edgeCnt;
            mSel        = 1'b0;
            opA         = -1;
            sbQ.delete();
        end else if (opA >= 0) begin
            if (!opRev && edgeCnt == opA + Q + S) begin
                if (aliveModel(opTgt, edgeCnt) == 0) begin
                    opRev = 1'b1;
                end else begin
                    mSel = opTgt;
                    opA  = -1;
                    sbQ.push_back('{isErr: 1'b0, due: edgeCnt});
                end
            end else if (opRev && edgeCnt == opA + Q + 2 * S) begin
                opA = -1;
                sbQ.push_back('{isErr: 1'b1, due: edgeCnt});
            end
        end else if (req_valid && !mBusy) begin
            acceptFlag = 1'b1;
            lastAccept = edgeCnt;
            if (req_sel == mSel) begin
                sbQ.push_back('{isErr: 1'b0, due: edgeCnt});
            end else if (aliveModel(req_sel, edgeCnt) == 0) begin
                sbQ.push_back('{isErr: 1'b1, due: edgeCnt});
            end else begin
                opA    = edgeCnt;
                opTgt  = req_sel;
                opPrev = mSel;
                opRev  = 1'b0;
            end
        end
    end

    // Monitor: compares levels against the model timeline and pops the scoreboard on pulses.
    always @(negedge clk_100m) begin
        bit        eBusy;
        bit        eTree;
        bit        eSel;
        int        a;
        expPulse_t head;
        if (edgeCnt <= lastLowEdge + S) begin
            eBusy = 1'b1;
            eTree = 1'b0;
            eSel  = 1'b0;
        end else if (opA >= 0) begin
            eBusy = 1'b1;
            eTree = 1'b0;
            if (edgeCnt < opA + Q)          eSel = opPrev;
            else if (!opRev)                eSel = opTgt;
            else if (edgeCnt < opA + Q + S) eSel = opTgt;
            else                            eSel = opPrev;
        end else begin
            eBusy = 1'b0;
            eTree = 1'b1;
            eSel  = mSel;
        end
        mBusy = eBusy;
        checkOutput("busy", busy, eBusy);
        checkOutput("req_ready", req_ready, !eBusy);
        checkOutput("tree_rst_n", tree_rst_n, eTree);
        checkOutput("ck_sel", ck_sel, eSel);
        checkOutput("pulse_exclusive", done_pulse & err_pulse, 0);
        for (int i = 0; i < 2; i++) begin
            a = aliveModel(i, edgeCnt + 1);
            if (a != 2) checkOutput($sformatf("ck_alive[%0d]", i), ck_alive[i], a);
        end
        if (done_pulse || err_pulse) begin
            if (sbQ.size() == 0) begin
                checkOutput("unexpected_pulse", {err_pulse, done_pulse}, 0);
            end else begin
                head = sbQ.pop_front();
                checkOutput("pulse_edge", edgeCnt, head.due);
                checkOutput("pulse_is_err", err_pulse, head.isErr);
            end
        end else if (sbQ.size() > 0 && sbQ[0].due < edgeCnt) begin
            head = sbQ.pop_front();
            checkOutput($sformatf("pulse_at_due_%0d", head.due), done_pulse | err_pulse, 1);
        end
    end

    // Raise a request and hold it until the model sees it accepted.
    task automatic applyStimulus(input bit sel);
        int n;
        req_valid = 1'b1;
        req_sel   = sel;
        n = 0;
        do begin
            @(negedge clk_100m);
            n++;
        end while (!acceptFlag && n < 400);
        checkOutput("req_accept", acceptFlag, 1);
        req_valid = 1'b0;
    endtask

    task automatic waitIdle(input int budget);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < budget) begin
            @(negedge clk_100m);
            n++;
        end
        checkOutput("wait_idle", busy, 0);
    endtask

    initial begin
        int n;
        int which;
        repeat (5) @(negedge clk_100m);
        reset_n = 1'b1;
        waitIdle(200);

        // Switch to 125 MHz, no-op on 125, switch back, no-op on 100.
        applyStimulus(1'b1);
        waitIdle(400);
        applyStimulus(1'b1);
        applyStimulus(1'b0);
        waitIdle(400);
        applyStimulus(1'b0);

        // 125 MHz heartbeat dead: two back-to-back requests are both refused.
        hbEn[1] = 1'b0;
        repeat (300) @(negedge clk_100m);
        applyStimulus(1'b1);
        applyStimulus(1'b1);
        hbEn[1] = 1'b1;
        repeat (60) @(negedge clk_100m);

        // Heartbeat dies during SETTLE: revert path.
        applyStimulus(1'b1);
        n = 0;
        while (edgeCnt < lastAccept + 20 && n < 100) begin
            @(negedge clk_100m);
            n++;
        end
        hbEn[1] = 1'b0;
        waitIdle(400);
        hbEn[1] = 1'b1;
        repeat (60) @(negedge clk_100m);

        // Reset mid-switch with the request still held high.
        applyStimulus(1'b1);
        req_valid = 1'b1;
        n = 0;
        while (edgeCnt < lastAccept + 29 && n < 100) begin
            @(negedge clk_100m);
            n++;
        end
        reset_n = 1'b0;
        repeat (3) @(negedge clk_100m);
        reset_n = 1'b1;
        n = 0;
        do begin
            @(negedge clk_100m);
            n++;
        end while (!acceptFlag && n < 300);
        checkOutput("accept_after_reset", acceptFlag, 1);
        req_valid = 1'b0;
        waitIdle(400);

        // Randomised requests with occasional heartbeat start/stop while idle.
        for (int k = 0; k < 24; k++) begin
            if ($urandom_range(0, 3) == 0) begin
                which = $urandom_range(0, 1);
                hbEn[which] = !hbEn[which];
                repeat (60) @(negedge clk_100m);
            end
            repeat ($urandom_range(0, 4)) @(negedge clk_100m);
            applyStimulus(1'($urandom_range(0, 1)));
            waitIdle(400);
        end

        repeat (10) @(negedge clk_100m);
        checkOutput("scoreboard_empty", sbQ.size(), 0);
        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL global_timeout: simulation did not finish, errors=%0d checks=%0d", errCount, checkCount);
        $fatal(1, "[TB] global timeout");
    end

endmodule
